// File: rtl/mem_window_reader.sv
// Loads an IMG_W x IMG_H frame from a combinational ROM, then streams every interior
// 3x3 window in raster order over a valid/ready handshake.
module mem_window_reader #(
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 4,
    parameter int unsigned IMG_W = 4,
    parameter int unsigned IMG_H = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_data,
    output logic [9*DW-1:0] win_data,
    output logic [AW-1:0]   win_row,
    output logic [AW-1:0]   win_col,
    output logic            win_valid,
    input  logic            win_ready,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {StIdle, StLoad, StEmit, StFin} state_e;

    localparam int unsigned   NPix     = IMG_W * IMG_H;
    localparam logic [AW-1:0] LastAddr = AW'(NPix - 1);
    localparam logic [AW-1:0] LastRow  = AW'(IMG_H - 2);
    localparam logic [AW-1:0] LastCol  = AW'(IMG_W - 2);
    localparam logic [AW-1:0] FirstCtr = AW'(1);
    localparam logic [AW:0]   ImgWL    = (AW+1)'(IMG_W);
    localparam logic [AW:0]   OneL     = (AW+1)'(1);

    state_e              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [AW-1:0]       row_q, row_d;
    logic [AW-1:0]       col_q, col_d;
    logic [9*DW-1:0]     data_q, data_d;
    logic [DW-1:0]       fbuf_q [2**AW];

    logic [AW-1:0]       cen_r, cen_c;
    logic [AW:0]         idx;
    logic [DW-1:0]       pix;
    logic [9*DW-1:0]     win_calc;

    always_ff @(posedge clk) begin
        if (state_q == StLoad) begin
            fbuf_q[addr_q] <= mem_data;
        end
    end

    // Centre of the window that would be loaded next.
    always_comb begin
        cen_r = row_q;
        cen_c = col_q + 1'b1;
        if (state_q == StLoad) begin
            cen_r = FirstCtr;
            cen_c = FirstCtr;
        end else if (col_q == LastCol) begin
            cen_r = row_q + 1'b1;
            cen_c = FirstCtr;
        end
    end

    // The final LOAD edge writes the buffer and loads the first window together,
    // so the pixel being written is bypassed straight from mem_data.
    always_comb begin
        win_calc = '0;
        idx      = '0;
        pix      = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                idx = ({1'b0, cen_r} + (AW+1)'(dr) - OneL) * ImgWL
                    + {1'b0, cen_c} + (AW+1)'(dc) - OneL;
                pix = fbuf_q[idx[AW-1:0]];
                if (state_q == StLoad && idx[AW-1:0] == addr_q) begin
                    pix = mem_data;
                end
                win_calc[(dr*3+dc)*DW +: DW] = pix;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        row_d   = row_q;
        col_d   = col_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                addr_d = '0;
                if (start) state_d = StLoad;
            end
            StLoad: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == LastAddr) begin
                    state_d = StEmit;
                    addr_d  = '0;
                    row_d   = cen_r;
                    col_d   = cen_c;
                    data_d  = win_calc;
                end
            end
            StEmit: begin
                if (win_ready) begin
                    if (row_q == LastRow && col_q == LastCol) begin
                        state_d = StFin;
                        row_d   = '0;
                        col_d   = '0;
                        data_d  = '0;
                    end else begin
                        row_d  = cen_r;
                        col_d  = cen_c;
                        data_d = win_calc;
                    end
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            col_q   <= col_d;
            data_q  <= data_d;
        end
    end

    assign mem_addr  = (state_q == StLoad) ? addr_q : '0;
    assign win_data  = data_q;
    assign win_row   = row_q;
    assign win_col   = col_q;
    assign win_valid = (state_q == StEmit);
    assign busy      = (state_q == StLoad) || (state_q == StEmit);
    assign done      = (state_q == StFin);

endmodule

// File: tb/tb_mem_window_reader.sv
// Scoreboard bench for mem_window_reader: expected windows are queued by the stimulus
// and popped by a monitor on every handshake.
module tb_mem_window_reader;

    localparam int DW = 8;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data;
    logic [9*DW-1:0] win_data;
    logic [AW-1:0]   win_row;
    logic [AW-1:0]   win_col;
    logic            win_valid;
    logic            win_ready = 1'b1;
    logic            busy;
    logic            done;
    logic            rom_inv = 1'b0;

    typedef struct packed {
        logic [9*DW-1:0] data;
        logic [AW-1:0]   row;
        logic [AW-1:0]   col;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    mem_window_reader #(.DW(DW), .AW(AW), .IMG_W(4), .IMG_H(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .win_data  (win_data),
        .win_row   (win_row),
        .win_col   (win_col),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    assign mem_data = rom_inv ? DW'(4'd15 - mem_addr) : DW'(mem_addr);

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [9*DW-1:0] w9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {DW'(a8), DW'(a7), DW'(a6), DW'(a5), DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    task automatic push_win(input int r, input int c, input logic [9*DW-1:0] d);
        exp_t e;
        e.data = d;
        e.row  = AW'(r);
        e.col  = AW'(c);
        exp_q.push_back(e);
    endtask

    task automatic push_std();
        push_win(1, 1, w9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        push_win(1, 2, w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        push_win(2, 1, w9(4, 5, 6, 8, 9, 10, 12, 13, 14));
        push_win(2, 2, w9(5, 6, 7, 9, 10, 11, 13, 14, 15));
    endtask

    task automatic push_inv();
        push_win(1, 1, w9(15, 14, 13, 11, 10, 9, 7, 6, 5));
        push_win(1, 2, w9(14, 13, 12, 10, 9, 8, 6, 5, 4));
        push_win(2, 1, w9(11, 10, 9, 7, 6, 5, 3, 2, 1));
        push_win(2, 2, w9(10, 9, 8, 6, 5, 4, 2, 1, 0));
    endtask

    // Returns 1 ns after the edge E that samples start.
    task automatic start_pass();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: done not seen within 100 cycles, expected a done pulse", name);
        end
    endtask

    // Monitor: scoreboard pop on each handshake, hold check while stalled.
    logic        stalled = 1'b0;
    logic [79:0] held;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (win_valid && stalled) check("stall_hold", {win_data, win_row, win_col}, held);
        if (win_valid && win_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_window: got row %0d col %0d, expected none",
                         win_row, win_col);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("window", {win_data, win_row, win_col}, {e.data, e.row, e.col});
            end
        end
        stalled = win_valid && !win_ready;
        held    = {win_data, win_row, win_col};
    end

    initial begin
        int dc;
        // Reset state
        #3;
        check("rst_mem_addr", 80'(mem_addr), 80'd0);
        check("rst_outputs", {win_data, win_row, win_col, win_valid, busy, done}, 80'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic pass: address sequence, latency, done timing
        push_std();
        start_pass();
        for (int i = 0; i < 16; i++) begin
            check("load_addr", 80'(mem_addr), 80'(i));
            check("load_busy", 80'(busy), 80'd1);
            if (i == 15) check("no_early_valid", 80'(win_valid), 80'd0);
            else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        check("valid_after_E16", 80'(win_valid), 80'd1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("done_at_E20", {77'd0, done, busy, win_valid}, 80'b100);
        @(posedge clk); #1;
        check("done_one_cycle", 80'(done), 80'd0);
        check("pass1_all_windows", 80'(exp_q.size()), 80'd0);

        // Backpressure during window (1,2)
        push_std();
        start_pass();
        repeat (17) begin
            @(posedge clk); #1;
        end
        win_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        win_ready = 1'b1;
        wait_done("stall_done");
        @(posedge clk); #1;
        check("stall_all_windows", 80'(exp_q.size()), 80'd0);

        // start pulses during LOAD and EMIT are ignored
        dc = done_cnt;
        push_std();
        start_pass();
        repeat (4) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("no_addr_restart", 80'(mem_addr), 80'd5);
        repeat (11) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignore_done");
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("ignore_one_done", 80'(done_cnt - dc), 80'd1);
        check("ignore_no_restart", 80'(busy), 80'd0);
        check("ignore_four_windows", 80'(exp_q.size()), 80'd0);

        // Asynchronous reset mid-LOAD, then a pass with the inverted ROM
        dc = done_cnt;
        start_pass();
        repeat (7) begin
            @(posedge clk); #1;
        end
        check("addr_before_rst", 80'(mem_addr), 80'd7);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_addr", 80'(mem_addr), 80'd0);
        check("async_rst_outputs", {win_data, win_row, win_col, win_valid, busy, done}, 80'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
        end
        check("abort_no_done", 80'(done_cnt - dc), 80'd0);
        check("abort_idle", 80'(busy), 80'd0);
        rom_inv = 1'b1;
        push_inv();
        start_pass();
        wait_done("inv_done");
        @(posedge clk); #1;
        check("inv_all_windows", 80'(exp_q.size()), 80'd0);

        // start held high: back-to-back passes
        rom_inv = 1'b0;
        push_std();
        push_std();
        start = 1'b1;
        wait_done("held_done1");
        @(posedge clk); #1;
        check("held_idle_after_fin", 80'(busy), 80'd0);
        @(posedge clk); #1;
        check("held_restart", {78'd0, busy, 1'b0} | 80'(mem_addr), 80'b10);
        start = 1'b0;
        wait_done("held_done2");
        @(posedge clk); #1;
        check("held_all_windows", 80'(exp_q.size()), 80'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
